bcd2bin_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the combinational bin2bcd path used for the score and number displays.
- Converts a packed multi-digit BCD entry (keypad/switch digits entered by a player) into a W-bit binary value, one digit per clock, most significant digit first.
- Feeds the game comparator logic.
- Uses a start/busy/done handshake and flags invalid digits and overflow.

---
 rtl/bcd2bin_seq_if.sv | 24 ++
 rtl/bcd2bin_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq_if.sv
// Handshake and data bundle between a digit-entry source and the BCD-to-binary converter.
// The master requests conversions; the slave (converter) returns the result and flags.
interface bcd2bin_seq_if #(
  parameter int W = 18,
  parameter int D = 6
);
  logic           start;
  logic [4*D-1:0] bcd;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           err;

  modport master (
    output start, bcd,
    input  bin, busy, done, ovf, err
  );

  modport slave (
    input  start, bcd,
    output bin, busy, done, ovf, err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + d.
// Saturates on overflow, flags digits above 9; all outputs registered.
//
// state  | meaning
// S_IDLE | waiting for start; latches bcd and clears accumulator/flags on accept
// S_CONV | folds one BCD digit per cycle into the accumulator
// S_DONE | single cycle; publishes bin/ovf/err and pulses done on the way out
module bcd2bin_seq #(
  parameter int W = 18,
  parameter int D = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  bcd2bin_seq_if.slave  bus
);

  localparam int BW = 4 * D;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   sreg_q, sreg_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [W-1:0]    bin_q, bin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_out_q, ovf_out_d;
  logic            err_out_q, err_out_d;

  logic [3:0]      digit;
  logic [W+3:0]    acc_wide;
  logic [W+3:0]    acc_x10;
  logic            acc_big;

  assign digit    = sreg_q[BW-1 -: 4];
  assign acc_wide = {4'b0000, acc_q};
  // acc is at most 2^W-1 between cycles, so acc*10+15 always fits in W+4 bits.
  assign acc_x10  = (acc_wide << 3) + (acc_wide << 1) + {{W{1'b0}}, digit};
  assign acc_big  = |acc_x10[W+3:W];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    bin_d     = bin_q;
    done_d    = 1'b0;
    ovf_out_d = ovf_out_q;
    err_out_d = err_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CONV;
          sreg_d  = bus.bcd;
          acc_d   = '0;
          cnt_d   = CW'(D - 1);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_CONV: begin
        if (digit > 4'd9) begin
          err_d = 1'b1;
        end
        if (acc_big) begin
          ovf_d = 1'b1;
          acc_d = '1;
        end else begin
          acc_d = acc_x10[W-1:0];
        end
        sreg_d = sreg_q << 4;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        ovf_out_d = ovf_q;
        err_out_d = err_q;
        // A bad digit makes the value meaningless, so it outranks saturation.
        if (err_q) begin
          bin_d = '0;
        end else if (ovf_q) begin
          bin_d = '1;
        end else begin
          bin_d = acc_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CONV);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sreg_q    <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      bin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_out_q <= ovf_out_d;
      err_out_q <= err_out_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_out_q;
  assign bus.err  = err_out_q;

endmodule
